// File: rtl/npu_pkg.sv
// Shared NPU defaults used by the datapath buffers.
package npu_pkg;

  localparam int DATA_W     = 16;
  localparam int OBUF_DEPTH = 8;

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous FIFO storage and wrap-around pointers; occupancy is tracked by the caller.
module npu_sync_fifo #(
  parameter int DATA_W = npu_pkg::DATA_W,
  parameter int DEPTH  = npu_pkg::OBUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // DEPTH is a power of two, so pointers wrap from DEPTH-1 to 0 by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; validity is carried by the occupancy count alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/relu_out_buffer.sv
// Output buffer after the ReLU stage: FIFO with valid/ready drain, occupancy and sticky overflow.
module relu_out_buffer #(
  parameter int DATA_W = npu_pkg::DATA_W,
  parameter int DEPTH  = npu_pkg::OBUF_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST_OBUF,
  input  logic [DATA_W-1:0]        ReLU_OUT,
  input  logic                     ReLU_VALID,
  output logic [DATA_W-1:0]        OBUF_DATA,
  output logic                     OBUF_VALID,
  input  logic                     OBUF_READY,
  output logic [$clog2(DEPTH):0]   OBUF_COUNT,
  output logic                     OBUF_FULL,
  output logic                     OBUF_EMPTY,
  output logic                     OBUF_OVF,
  input  logic                     CLR_OVF
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && OBUF_READY;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push  = ReLU_VALID && (!full || pop);

  npu_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST_OBUF),
    .wr_en   (push),
    .wr_data (ReLU_OUT),
    .rd_en   (pop),
    .rd_data (head)
  );

  always_ff @(posedge CLK) begin
    if (RST_OBUF) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  // A new overflow wins over a coincident clear.
  always_ff @(posedge CLK) begin
    if (RST_OBUF) begin
      ovf <= 1'b0;
    end else if (ReLU_VALID && !push) begin
      ovf <= 1'b1;
    end else if (CLR_OVF) begin
      ovf <= 1'b0;
    end
  end

  // Unwritten storage is masked so the output reads zero whenever nothing is held.
  assign OBUF_DATA  = empty ? '0 : head;
  assign OBUF_VALID = !empty;
  assign OBUF_COUNT = count;
  assign OBUF_FULL  = full;
  assign OBUF_EMPTY = empty;
  assign OBUF_OVF   = ovf;

endmodule

// File: tb/tb_relu_out_buffer.sv
// Directed self-checking bench for relu_out_buffer with a small queue reference model.
module tb_relu_out_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  logic                   CLK = 1'b0;
  logic                   RST_OBUF;
  logic [DATA_W-1:0]      ReLU_OUT;
  logic                   ReLU_VALID;
  logic [DATA_W-1:0]      OBUF_DATA;
  logic                   OBUF_VALID;
  logic                   OBUF_READY;
  logic [$clog2(DEPTH):0] OBUF_COUNT;
  logic                   OBUF_FULL;
  logic                   OBUF_EMPTY;
  logic                   OBUF_OVF;
  logic                   CLR_OVF;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] model_q [$];
  logic              model_ovf;
  logic [DATA_W-1:0] last_pop;
  logic              seen_aaaa;

  relu_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST_OBUF   (RST_OBUF),
    .ReLU_OUT   (ReLU_OUT),
    .ReLU_VALID (ReLU_VALID),
    .OBUF_DATA  (OBUF_DATA),
    .OBUF_VALID (OBUF_VALID),
    .OBUF_READY (OBUF_READY),
    .OBUF_COUNT (OBUF_COUNT),
    .OBUF_FULL  (OBUF_FULL),
    .OBUF_EMPTY (OBUF_EMPTY),
    .OBUF_OVF   (OBUF_OVF),
    .CLR_OVF    (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Post-edge status compared against the reference model.
  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(OBUF_COUNT), 32'(model_q.size()));
    check({tag, "_valid"}, 32'(OBUF_VALID), 32'(model_q.size() != 0));
    check({tag, "_full"},  32'(OBUF_FULL),  32'(model_q.size() == DEPTH));
    check({tag, "_empty"}, 32'(OBUF_EMPTY), 32'(model_q.size() == 0));
    check({tag, "_ovf"},   32'(OBUF_OVF),   32'(model_ovf));
    if (model_q.size() == 0) check({tag, "_idle_data"}, 32'(OBUF_DATA), 32'h0);
  endtask

  // One clock cycle: drive, check the pre-edge handshake, update the model, check post-edge state.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    logic exp_pop;
    logic exp_push;
    int   size_before;
    ReLU_VALID = v;
    ReLU_OUT   = d;
    OBUF_READY = r;
    CLR_OVF    = c;
    #1;
    size_before = model_q.size();
    exp_pop  = r && (size_before != 0);
    exp_push = v && ((size_before < DEPTH) || exp_pop);
    if (size_before == 0) check("no_bypass", 32'(OBUF_VALID), 32'h0);
    if (OBUF_VALID && r && OBUF_DATA == 16'hAAAA) seen_aaaa = 1'b1;
    if (exp_pop) begin
      check("pop_valid", 32'(OBUF_VALID), 32'h1);
      check("pop_data", 32'(OBUF_DATA), 32'(model_q[0]));
      last_pop = model_q.pop_front();
    end
    if (v && !exp_push) model_ovf = 1'b1;
    else if (c)         model_ovf = 1'b0;
    if (exp_push) model_q.push_back(d);
    @(posedge CLK);
    #1;
    check_state("cyc");
  endtask

  // Reset with push, pop and clear all requested, to show reset wins.
  task automatic do_reset();
    RST_OBUF   = 1'b1;
    ReLU_VALID = 1'b1;
    ReLU_OUT   = 16'h9999;
    OBUF_READY = 1'b1;
    CLR_OVF    = 1'b1;
    @(posedge CLK);
    #1;
    RST_OBUF   = 1'b0;
    ReLU_VALID = 1'b0;
    OBUF_READY = 1'b0;
    CLR_OVF    = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    check("rst_count", 32'(OBUF_COUNT), 32'h0);
    check("rst_valid", 32'(OBUF_VALID), 32'h0);
    check("rst_empty", 32'(OBUF_EMPTY), 32'h1);
    check("rst_full",  32'(OBUF_FULL),  32'h0);
    check("rst_ovf",   32'(OBUF_OVF),   32'h0);
    check("rst_data",  32'(OBUF_DATA),  32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && model_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drained_empty", 32'(OBUF_EMPTY), 32'h1);
  endtask

  initial begin
    RST_OBUF   = 1'b1;
    ReLU_OUT   = '0;
    ReLU_VALID = 1'b0;
    OBUF_READY = 1'b0;
    CLR_OVF    = 1'b0;
    model_ovf  = 1'b0;
    last_pop   = '0;
    seen_aaaa  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Streaming with ready high: each word visible exactly one cycle after its push.
    cycle(1'b1, 16'h0001, 1'b1, 1'b0);
    check("first_valid", 32'(OBUF_VALID), 32'h1);
    check("first_data",  32'(OBUF_DATA),  32'h0001);
    cycle(1'b1, 16'h7FFF, 1'b1, 1'b0);
    check("second_data", 32'(OBUF_DATA), 32'h7FFF);
    cycle(1'b1, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("stream_last", 32'(last_pop), 32'h0000);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill, then overflow with 0xAAAA; clear; coincident clear and overflow.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    check("fill_full",  32'(OBUF_FULL),  32'h1);
    check("fill_count", 32'(OBUF_COUNT), 32'h8);
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check("ovf_set",   32'(OBUF_OVF),   32'h1);
    check("ovf_count", 32'(OBUF_COUNT), 32'h8);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("ovf_sticky", 32'(OBUF_OVF), 32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clear", 32'(OBUF_OVF), 32'h0);
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b1);
    check("ovf_clr_coincide", 32'(OBUF_OVF), 32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();
    check("aaaa_never_out", 32'(seen_aaaa), 32'h0);
    check("ovf_drain_last", 32'(last_pop), 32'h1007);

    // Full with push and pop together: accepted, no overflow, emerges last.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("full_pp_count", 32'(OBUF_COUNT), 32'h8);
    check("full_pp_ovf",   32'(OBUF_OVF),   32'h0);
    drain();
    check("full_pp_last", 32'(last_pop), 32'hBEEF);

    // Back-pressure: head held stable for five cycles, then popped.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check("hold_data",  32'(OBUF_DATA),  32'h1234);
      check("hold_valid", 32'(OBUF_VALID), 32'h1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("hold_pop", 32'(last_pop), 32'h1234);

    // Reset mid-occupancy discards stored words.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0055, 1'b0, 1'b0);
    check("post_rst_head", 32'(OBUF_DATA), 32'h0055);
    drain();
    check("post_rst_only", 32'(last_pop), 32'h0055);

    // Twenty words in bursts of four with random ready, crossing the pointer wrap.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'h4000 + 16'(b * 4 + i), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 64 && model_q.size() != 0; i++) cycle(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
      check("burst_empty", 32'(OBUF_EMPTY), 32'h1);
    end
    check("burst_last", 32'(last_pop), 32'h4013);
    check("burst_no_ovf", 32'(OBUF_OVF), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/relu_out_buffer.md
RELU_OUT_BUFFER -- requirements
Module: relu_out_buffer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of FIFO entries; it SHALL be a power of two, 2..16.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_OBUF  input  1  SHALL be the synchronous, active-high reset.
REQ-005 ReLU_OUT  input  DATA_W  SHALL be the word from the ReLU stage.
REQ-006 ReLU_VALID  input  1  SHALL be the push strobe: ReLU_OUT holds a new result this cycle.
REQ-007 OBUF_DATA  output  DATA_W  SHALL be the head word.
REQ-008 OBUF_VALID  output  1  SHALL be high when OBUF_DATA holds a valid head word.
REQ-009 OBUF_READY  input  1  SHALL be the consumer accept signal.
REQ-010 OBUF_COUNT  output  $clog2(DEPTH)+1  SHALL be the current occupancy.
REQ-011 OBUF_FULL / OBUF_EMPTY  output  1 each  SHALL be the occupancy flags.
REQ-012 OBUF_OVF  output  1  SHALL be the sticky overflow flag.
REQ-013 CLR_OVF  input  1  SHALL clear OBUF_OVF.

Function
REQ-014 A push SHALL occur on each cycle with ReLU_VALID=1 and (OBUF_FULL=0 or a pop in the same cycle).
REQ-015 A pop SHALL occur on each cycle with OBUF_VALID=1 and OBUF_READY=1.
REQ-016 Data SHALL leave in push order, bit-exact, with no sign or width change.
REQ-017 A pushed word SHALL appear on OBUF_DATA no earlier than the cycle after its push.
- If the FIFO is empty at the push, it SHALL appear with OBUF_VALID exactly one cycle later.
- Empty-to-output bypass in the same cycle SHALL NOT occur.
REQ-018 OBUF_DATA and OBUF_VALID SHALL remain stable while OBUF_VALID=1 and OBUF_READY=0.
REQ-019 OBUF_COUNT SHALL update one cycle after the push/pop edge:
- +1 on push only.
- -1 on pop only.
- Unchanged on simultaneous push and pop.
REQ-020 OBUF_FULL SHALL equal (OBUF_COUNT==DEPTH); OBUF_EMPTY SHALL equal (OBUF_COUNT==0); OBUF_VALID SHALL equal !OBUF_EMPTY.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-022 ReLU_VALID=1 while full with no pop SHALL:
- drop the word;
- leave stored data and OBUF_COUNT unchanged;
- set OBUF_OVF on the next edge.
REQ-023 ReLU_VALID=1 while full with a pop in the same cycle SHALL accept the word without setting OBUF_OVF.
REQ-024 OBUF_OVF SHALL stay set until CLR_OVF=1 or reset; if CLR_OVF and a new overflow coincide, OBUF_OVF SHALL end up set.
REQ-025 OBUF_READY=1 while empty SHALL have no effect.

Reset
REQ-026 RST_OBUF=1 at a rising edge SHALL:
- zero both pointers;
- set OBUF_COUNT=0, OBUF_EMPTY=1, OBUF_FULL=0, OBUF_VALID=0, OBUF_OVF=0, OBUF_DATA=0.
REQ-027 Reset SHALL take priority over push, pop and CLR_OVF; words stored before reset SHALL be lost and SHALL NOT reappear.
REQ-028 The storage array SHALL NOT need a reset.

Structure
REQ-029 DATA_W (16) and OBUF_DEPTH (8) defaults SHALL live in the shared package npu_pkg.
REQ-030 The storage and pointers SHALL be a single sub-module, npu_sync_fifo; relu_out_buffer SHALL add the overflow, count and handshake logic around it.

Verification
REQ-031 Reset, then push 0x0001, 0x7FFF, 0x0000 with OBUF_READY=1 -> same three words out in order; first OBUF_VALID one cycle after the first push.
REQ-032 Push 8 words with OBUF_READY=0 -> OBUF_FULL=1, OBUF_COUNT=8; a 9th push 0xAAAA -> OBUF_OVF=1, 0xAAAA never output.
REQ-033 When full, ReLU_VALID=1 and OBUF_READY=1 in the same cycle -> count stays 8, OBUF_OVF=0, pushed word emerges last.
REQ-034 Hold OBUF_READY=0 with 0x1234 at the head for 5 cycles -> OBUF_DATA=0x1234 stable throughout; pop on release.
REQ-035 Push 3 words, assert RST_OBUF for 1 cycle -> OBUF_VALID=0, OBUF_COUNT=0; after reset push 0x0055 -> only 0x0055 is output.
REQ-036 Push 20 words in bursts with random OBUF_READY -> order is preserved across pointer wrap and no overflow occurs.
